miriscv_data_mem: RTL and testbench
===================================

MIRISCV_DATA_MEM -- requirements
Module: miriscv_data_mem

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words stored; it is a power of two, minimum 4.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, meaning the number of wait-state cycles inserted between grant and response, 0..15.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk_i, input, 1 bit: the clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port data_req_i, input, 1 bit: access request, held by the LSU until granted.
REQ-007 SHALL have port data_we_i, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port data_be_i, input, 4 bits: byte enables; bit k selects byte k of the word.
REQ-009 SHALL have port data_addr_i, input, 32 bits: byte address; bits [1:0] are ignored.
REQ-010 SHALL have port data_wdata_i, input, 32 bits: write data.
REQ-011 SHALL have port data_gnt_o, output, 1 bit: request accepted this cycle.
REQ-012 SHALL have port data_rvalid_o, output, 1 bit: response valid, one-cycle pulse.
REQ-013 SHALL have port data_rdata_o, output, 32 bits: read data.

Function
REQ-014 SHALL implement states IDLE, WAIT and RESP, encoded in a state register.
REQ-015 SHALL drive data_gnt_o = (state==IDLE) & data_req_i & !rst_i, combinationally; no grant in WAIT or RESP.
REQ-016 SHALL, on a grant cycle N, latch the word index (addr[31:2]), we, be and wdata into request registers.
- Move to RESP if WAIT_CYCLES==0.
- Otherwise move to WAIT with wait counter = WAIT_CYCLES-1.
REQ-017 SHALL, in WAIT, decrement the counter each cycle and go to RESP on the cycle the counter is 0.
REQ-018 SHALL perform the memory access on the edge entering RESP, so data_rvalid_o = 1 exactly in cycle N+1+WAIT_CYCLES, for one cycle; RESP always returns to IDLE next.
REQ-019 SHALL, on write, update only the bytes whose be bit is 1; be=4'b0000 changes nothing but still produces rvalid.
REQ-020 SHALL, on read, register the full word (be ignored) into data_rdata_o on the edge entering RESP.
REQ-021 SHALL, on write, load data_rdata_o with 32'h0 for that response.
REQ-022 SHALL hold data_rdata_o at its last value while rvalid is 0.
REQ-023 SHALL accept a new request no earlier than the IDLE cycle after RESP; back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
REQ-024 SHALL ignore changes on data_addr_i/we/be/wdata after the grant cycle, because the latched copies are used.
REQ-025 SHALL, when a read follows a write to the same word, return the written data (no stale read).

Reset
REQ-026 SHALL, while rst_i=1 at an edge, set state=IDLE, counter=0, data_rvalid_o=0 and data_rdata_o=32'h0; data_gnt_o SHALL be 0 in any cycle where rst_i=1.
REQ-027 SHALL give reset priority over an access: rst_i=1 in WAIT, or on the edge that would enter RESP, SHALL abort the access, commit no write and produce no rvalid.
REQ-028 SHALL NOT clear memory contents on reset; contents are undefined until written.

Configuration
REQ-029 SHALL honour macro MIRISCV_DATA_MEM_BOUNDS_CHECK_EN.
- Defined: a word index >= DEPTH_WORDS is out of range. Writes to it are dropped; reads return 32'hDEADBEEF. Grant and rvalid timing is unchanged.
- Undefined: the word index is taken modulo DEPTH_WORDS (low log2(DEPTH_WORDS) bits), so accesses alias/wrap; no bounds logic is present.

Verification
REQ-030 SHALL cover: WAIT_CYCLES=1; write 0x1234_5678 to addr 0x10 with be=4'hF; gnt at cycle N, then read 0x10 -> rvalid at N+2; rdata=0x1234_5678.
REQ-031 SHALL cover: word holds 0xAABBCCDD; write 0x1122_3344 with be=4'b0101, then read -> rdata=0xAA22CC44; a write with be=0 leaves the word unchanged and still pulses rvalid.
REQ-032 SHALL cover: WAIT_CYCLES=0 and WAIT_CYCLES=3; req held continuously -> gnt pulses exactly every 2 and every 5 cycles respectively; rvalid is 1 and 4 cycles after each gnt.
REQ-033 SHALL cover: write granted, rst_i=1 during WAIT (WAIT_CYCLES=3) -> no rvalid, rdata=0; a later read of that word returns the previous contents.
REQ-034 SHALL cover: DEPTH_WORDS=1024; write 0x5A5A_5A5A to byte addr 0x1000, then read 0x0 -> 0x5A5A_5A5A when the macro is undefined; with the macro defined, the read of 0x1000 returns 0xDEADBEEF and addr 0x0 is unchanged.
REQ-035 SHALL cover: change addr/wdata in the cycle after gnt -> the access uses the values latched at the grant cycle.

Source files
------------

// File: rtl/miriscv_data_mem.sv
// miriscv_data_mem: single-port word-organised data memory for the miriscv LSU.
// A request is granted in IDLE, optionally waits WAIT_CYCLES cycles, then
// returns a single-cycle rvalid pulse with read data (or zero for writes).
// Optional feature: define MIRISCV_DATA_MEM_BOUNDS_CHECK_EN to drop writes to,
// and return 32'hDEADBEEF from, word indices >= DEPTH_WORDS instead of wrapping.
module miriscv_data_mem #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [3:0]        wait_cnt;
  logic [3:0]        wait_cnt_next;
  logic              enter_resp;

  logic [29:0]       req_idx;
  logic              req_we;
  logic [3:0]        req_be;
  logic [31:0]       req_wdata;

  logic [29:0]       acc_idx;
  logic              acc_we;
  logic [3:0]        acc_be;
  logic [31:0]       acc_wdata;
  logic              acc_in_range;
  logic [IDX_W-1:0]  mem_idx;

  logic [31:0]       mem [DEPTH_WORDS];

  logic              unused_bits;

  assign data_gnt_o = (state == IDLE) & data_req_i & ~rst_i;

`ifdef MIRISCV_DATA_MEM_BOUNDS_CHECK_EN
  assign acc_in_range = (acc_idx < 30'(DEPTH_WORDS));
`else
  assign acc_in_range = 1'b1;
`endif

  assign mem_idx     = acc_idx[IDX_W-1:0];
  assign unused_bits = ^{data_addr_i[1:0], acc_idx};

  // With zero wait states the access happens on the grant edge itself, so the live inputs are used in IDLE; otherwise the latched copy.
  always_comb begin
    acc_idx   = req_idx;
    acc_we    = req_we;
    acc_be    = req_be;
    acc_wdata = req_wdata;
    if (state == IDLE) begin
      acc_idx   = data_addr_i[31:2];
      acc_we    = data_we_i;
      acc_be    = data_be_i;
      acc_wdata = data_wdata_i;
    end
  end

  // Next-state logic; enter_resp marks the edge on which the memory access is performed.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    enter_resp    = 1'b0;
    case (state)
      IDLE: begin
        if (data_gnt_o) begin
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next    = WAIT;
            wait_cnt_next = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt - 4'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and wait counter registers; reset aborts any access in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Capture the request on the grant cycle so later input changes cannot affect it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_idx   <= 30'd0;
      req_we    <= 1'b0;
      req_be    <= 4'd0;
      req_wdata <= 32'd0;
    end else if (data_gnt_o) begin
      req_idx   <= data_addr_i[31:2];
      req_we    <= data_we_i;
      req_be    <= data_be_i;
      req_wdata <= data_wdata_i;
    end
  end

  // Byte-masked write on the edge entering RESP; memory contents survive reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && enter_resp && acc_we && acc_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) begin
          mem[mem_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

  // Response register: one-cycle rvalid pulse, read data held between responses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_rvalid_o <= 1'b0;
      data_rdata_o  <= 32'h0;
    end else begin
      data_rvalid_o <= enter_resp;
      if (enter_resp) begin
        if (acc_we) begin
          data_rdata_o <= 32'h0;
        end else if (!acc_in_range) begin
          data_rdata_o <= 32'hDEADBEEF;
        end else begin
          data_rdata_o <= mem[mem_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_miriscv_data_mem.sv
// tb_miriscv_data_mem: scoreboard bench for miriscv_data_mem.
// Three instances run side by side with WAIT_CYCLES = 1, 0 and 3; directed
// accesses push the expected response cycle and data, and a monitor pops and
// compares whenever any instance raises rvalid.
module tb_miriscv_data_mem;

  typedef struct {
    int          id;
    int          cyc;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst    [3];
  logic        req    [3];
  logic        we     [3];
  logic [3:0]  be     [3];
  logic [31:0] addr   [3];
  logic [31:0] wdata  [3];
  logic        gnt    [3];
  logic        rvalid [3];
  logic [31:0] rdata  [3];

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb [$];
  exp_t mon_e;

  // Free-running clock and a cycle counter used to timestamp grants and responses.
  always #5 clk = ~clk;

  // Cycle counter advances on every rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      miriscv_data_mem #(
        .DEPTH_WORDS(1024),
        .WAIT_CYCLES((g == 0) ? 1 : ((g == 1) ? 0 : 3))
      ) dut (
        .clk_i        (clk),
        .rst_i        (rst[g]),
        .data_req_i   (req[g]),
        .data_we_i    (we[g]),
        .data_be_i    (be[g]),
        .data_addr_i  (addr[g]),
        .data_wdata_i (wdata[g]),
        .data_gnt_o   (gnt[g]),
        .data_rvalid_o(rvalid[g]),
        .data_rdata_o (rdata[g])
      );
    end
  endgenerate

  function automatic int waitCycles(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic pushExpect(input int d, input int c, input logic [31:0] v);
    exp_t e;
    e.id   = d;
    e.cyc  = c;
    e.data = v;
    sb.push_back(e);
  endtask

  // Issue one access on instance d; must be called just after a rising edge.
  task automatic applyStimulus(input int d, input logic w, input logic [3:0] b,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] expv, input bit scramble,
                               input bit abort_req);
    bit got = 1'b0;
    int n   = 0;
    req[d]   = 1'b1;
    we[d]    = w;
    be[d]    = b;
    addr[d]  = a;
    wdata[d] = wd;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (gnt[d]) begin
        got = 1'b1;
        n   = cyc;
      end
      @(posedge clk);
      #1;
    end
    req[d] = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL grant_timeout dut=%0d actual=no_grant required=grant", d);
    end else if (abort_req) begin
      rst[d] = 1'b1;
      @(posedge clk);
      #1;
      rst[d] = 1'b0;
      @(negedge clk);
      checkOutput("abort_rvalid", {31'b0, rvalid[d]}, 32'h0);
      checkOutput("abort_rdata", rdata[d], 32'h0);
      @(posedge clk);
      #1;
    end else begin
      pushExpect(d, n + 1 + waitCycles(d), expv);
      if (scramble) begin
        addr[d]  = 32'h20;
        wdata[d] = 32'hBAD0BAD0;
        be[d]    = 4'h0;
      end
    end
  endtask

  // Hold a read request continuously and check the spacing between grants.
  task automatic holdReads(input int d, input logic [31:0] a, input logic [31:0] expv,
                           input int n_grants, input int period);
    int prev = -1;
    int cnt  = 0;
    req[d]  = 1'b1;
    we[d]   = 1'b0;
    be[d]   = 4'hF;
    addr[d] = a;
    for (int i = 0; i < n_grants * period + 10 && cnt < n_grants; i++) begin
      @(negedge clk);
      if (gnt[d]) begin
        if (prev >= 0) checkOutput("gnt_period", 32'(cyc - prev), 32'(period));
        pushExpect(d, cyc + 1 + waitCycles(d), expv);
        prev = cyc;
        cnt++;
      end
      @(posedge clk);
      #1;
    end
    req[d] = 1'b0;
    if (cnt < n_grants) begin
      checks++;
      errors++;
      $display("[TB] FAIL held_grants dut=%0d actual=%0d required=%0d", d, cnt, n_grants);
    end
  endtask

  // Let outstanding responses drain; anything left over is a missing rvalid.
  task automatic waitIdle();
    for (int i = 0; i < 60 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL missing_rvalid actual=%0d_pending required=0_pending", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every rvalid must match the oldest expected response in cycle and data.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rvalid[d] === 1'b1) begin
        if (sb.size() == 0 || sb[0].id != d) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_rvalid dut=%0d cycle=%0d actual=rvalid required=none", d, cyc);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("rvalid_cycle", 32'(cyc), 32'(mon_e.cyc));
          checkOutput("rdata", rdata[d], mon_e.data);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d]   = 1'b1;
      req[d]   = 1'b0;
      we[d]    = 1'b0;
      be[d]    = 4'h0;
      addr[d]  = 32'h0;
      wdata[d] = 32'h0;
    end
    req[0] = 1'b1;
    @(negedge clk);
    checkOutput("gnt_in_reset", {31'b0, gnt[0]}, 32'h0);
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b0;
      req[d] = 1'b0;
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checkOutput("reset_rvalid", {31'b0, rvalid[d]}, 32'h0);
      checkOutput("reset_rdata", rdata[d], 32'h0);
    end
    @(posedge clk);
    #1;

    applyStimulus(0, 1'b1, 4'hF, 32'h10, 32'h12345678, 32'h0, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 4'hF, 32'h10, 32'h0, 32'h12345678, 1'b0, 1'b0);
    waitIdle();
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput("rdata_hold", rdata[0], 32'h12345678);
    @(posedge clk);
    #1;

    applyStimulus(0, 1'b1, 4'hF, 32'h20, 32'hAABBCCDD, 32'h0, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 4'b0101, 32'h20, 32'h11223344, 32'h0, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 4'h0, 32'h20, 32'h0, 32'hAA22CC44, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 4'hF, 32'h20, 32'h0, 32'hAA22CC44, 1'b0, 1'b0);

    applyStimulus(0, 1'b1, 4'hF, 32'h30, 32'hCAFEF00D, 32'h0, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 4'hF, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 4'hF, 32'h20, 32'h0, 32'hAA22CC44, 1'b0, 1'b0);
    waitIdle();

    applyStimulus(1, 1'b1, 4'hF, 32'h40, 32'h01020304, 32'h0, 1'b0, 1'b0);
    holdReads(1, 32'h40, 32'h01020304, 4, 2);
    waitIdle();
    applyStimulus(2, 1'b1, 4'hF, 32'h40, 32'h0A0B0C0D, 32'h0, 1'b0, 1'b0);
    holdReads(2, 32'h40, 32'h0A0B0C0D, 4, 5);
    waitIdle();

    applyStimulus(2, 1'b1, 4'hF, 32'h50, 32'h11111111, 32'h0, 1'b0, 1'b0);
    applyStimulus(2, 1'b0, 4'hF, 32'h50, 32'h0, 32'h11111111, 1'b0, 1'b0);
    waitIdle();
    applyStimulus(2, 1'b1, 4'hF, 32'h50, 32'h22222222, 32'h0, 1'b0, 1'b1);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    applyStimulus(2, 1'b0, 4'hF, 32'h50, 32'h0, 32'h11111111, 1'b0, 1'b0);
    waitIdle();

    applyStimulus(0, 1'b1, 4'hF, 32'h0, 32'h0F0F0F0F, 32'h0, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 4'hF, 32'h1000, 32'h5A5A5A5A, 32'h0, 1'b0, 1'b0);
`ifdef MIRISCV_DATA_MEM_BOUNDS_CHECK_EN
    applyStimulus(0, 1'b0, 4'hF, 32'h1000, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 4'hF, 32'h0, 32'h0, 32'h0F0F0F0F, 1'b0, 1'b0);
`else
    applyStimulus(0, 1'b0, 4'hF, 32'h0, 32'h0, 32'h5A5A5A5A, 1'b0, 1'b0);
`endif
    waitIdle();

    repeat (8) begin
      @(posedge clk);
      #1;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
